// File: rtl/control_unit_pkg.sv
// Shared encodings for the control unit: opcodes, ALU ops, FSM states, funsel and mux source codes.
// Pure declarations, no latency; no flow control.
package control_unit_pkg;

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_INC  = 4'h9;
    localparam logic [3:0] OP_BRA  = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_LDAR = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // ALU function per opcode, index 15 on the left; only opcodes 4..9 are meaningful.
    localparam logic [15:0][3:0] ALU_OP = {
        4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
        4'h9, 4'h2, 4'h8, 4'h7, 4'h6, 4'h4,
        4'h0, 4'h0, 4'h0, 4'h0
    };
    localparam logic [3:0] ALU_PASS_A = 4'h0;

    localparam logic [2:0] ST_T0   = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_T3   = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    localparam logic [3:0] ARF_PC     = 4'b0001;
    localparam logic [3:0] ARF_AR     = 4'b0010;
    localparam logic [3:0] ARF_SP     = 4'b0100;
    localparam logic [3:0] ARF_PCPAST = 4'b1000;

    localparam logic [1:0] OUT_PC     = 2'd0;
    localparam logic [1:0] OUT_AR     = 2'd1;
    localparam logic [1:0] OUT_SP     = 2'd2;
    localparam logic [1:0] OUT_PCPAST = 2'd3;

    localparam logic [1:0] MUXA_ALU = 2'd0;
    localparam logic [1:0] MUXA_MEM = 2'd1;
    localparam logic [1:0] MUXA_IR  = 2'd2;
    localparam logic [1:0] MUXA_ARF = 2'd3;

    localparam logic [1:0] MUXB_ALU = 2'd0;
    localparam logic [1:0] MUXB_MEM = 2'd1;
    localparam logic [1:0] MUXB_IR  = 2'd2;
    localparam logic [1:0] MUXB_ARF = 2'd3;

    // Memory write data: ALU result or the RF O1 port.
    localparam logic MUXC_ALU = 1'b0;
    localparam logic MUXC_RF  = 1'b1;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_BR,
        CLS_LDI,
        CLS_MOV,
        CLS_LDAR,
        CLS_NOP,
        CLS_HLT
    } instr_class_t;

    // R1..R4 sit at RF output codes 100..111; 0xx are the temporaries.
    function automatic logic [2:0] rf_osel(input logic [1:0] r);
        return {1'b1, r};
    endfunction

    function automatic logic [3:0] rf_onehot(input logic [1:0] r);
        return 4'b0001 << r;
    endfunction

endpackage

// File: rtl/control_unit_instr_decoder.sv
// Maps an opcode onto its execution class; purely combinational, zero latency.
// No flow control.
module instr_decoder
    import control_unit_pkg::*;
(
    input  logic [3:0]   i_opcode,
    output instr_class_t o_class
);

    always_comb begin
        o_class = CLS_NOP;
        case (i_opcode)
            OP_LDI:                                         o_class = CLS_LDI;
            OP_LD, OP_ST:                                   o_class = CLS_MEM;
            OP_MOV:                                         o_class = CLS_MOV;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_INC:  o_class = CLS_ALU;
            OP_BRA, OP_BEQ, OP_BNE:                         o_class = CLS_BR;
            OP_LDAR:                                        o_class = CLS_LDAR;
            OP_NOP:                                         o_class = CLS_NOP;
            OP_HLT:                                         o_class = CLS_HLT;
            default:                                        o_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore control FSM: two-cycle byte fetch, then 1 execute cycle (2 for LD/ST); 3 or 4 clocks per instruction.
// No backpressure; reset forces idle outputs plus PC/AR/SP clear without waiting for a clock.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] ir_in,
    input  logic [3:0]  alu_flag,
    output logic        IR_enable,
    output logic        IR_lh,
    output logic [1:0]  funsel_IR,
    output logic [3:0]  regsel_arf,
    output logic [1:0]  funsel_arf,
    output logic [1:0]  outasel,
    output logic [1:0]  outbsel,
    output logic [3:0]  regsel_rf,
    output logic [3:0]  rf_tsel,
    output logic [1:0]  funsel_rf,
    output logic [2:0]  rf_o1sel,
    output logic [2:0]  rf_o2sel,
    output logic [3:0]  funsel_alu,
    output logic [1:0]  MUXSelA,
    output logic [1:0]  MUXSelB,
    output logic        MUXSelC,
    output logic        wrMEM,
    output logic        csMEM,
    output logic        halted
);

    logic [2:0]   r_state;
    logic [2:0]   w_next_state;
    logic         r_z;
    logic [3:0]   w_opcode;
    logic [1:0]   w_rd;
    logic [1:0]   w_rs;
    logic         w_br_take;
    instr_class_t w_class;
    logic         w_unused;

    assign w_opcode = ir_in[15:12];
    assign w_rd     = ir_in[11:10];
    assign w_rs     = ir_in[9:8];
    // The immediate reaches the datapath through the IR mux path, and only Z is kept from the flags.
    assign w_unused = ^{ir_in[7:0], alu_flag[2:0]};

    instr_decoder u_dec (
        .i_opcode (w_opcode),
        .o_class  (w_class)
    );

    assign w_br_take = (w_opcode == OP_BRA)
                     | ((w_opcode == OP_BEQ) &  r_z)
                     | ((w_opcode == OP_BNE) & ~r_z);

    always_comb begin
        w_next_state = ST_T0;
        case (r_state)
            ST_T0:   w_next_state = ST_T1;
            ST_T1:   w_next_state = ST_T2;
            ST_T2: begin
                if (w_class == CLS_MEM)      w_next_state = ST_T3;
                else if (w_class == CLS_HLT) w_next_state = ST_HALT;
                else                         w_next_state = ST_T0;
            end
            ST_T3:   w_next_state = ST_T0;
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_T0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_T0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_T2) && (w_class == CLS_ALU)) begin
                r_z <= alu_flag[3];
            end
        end
    end

    always_comb begin
        IR_enable  = 1'b0;
        IR_lh      = 1'b0;
        funsel_IR  = 2'b00;
        regsel_arf = 4'b0000;
        funsel_arf = 2'b00;
        outasel    = 2'b00;
        outbsel    = 2'b00;
        regsel_rf  = 4'b0000;
        rf_tsel    = 4'b0000;
        funsel_rf  = 2'b00;
        rf_o1sel   = 3'b000;
        rf_o2sel   = 3'b000;
        funsel_alu = 4'b0000;
        MUXSelA    = 2'b00;
        MUXSelB    = 2'b00;
        MUXSelC    = 1'b0;
        wrMEM      = 1'b0;
        csMEM      = 1'b1;
        halted     = 1'b0;

        // Reset overrides the state decode so an in-flight store is dropped at once.
        if (!reset_n) begin
            regsel_arf = ARF_PC | ARF_AR | ARF_SP;
            funsel_arf = FS_CLR;
        end else begin
            case (r_state)
                ST_T0, ST_T1: begin
                    IR_enable  = 1'b1;
                    IR_lh      = (r_state == ST_T1);
                    funsel_IR  = FS_LOAD;
                    regsel_arf = ARF_PC;
                    funsel_arf = FS_INC;
                    outbsel    = OUT_PC;
                    csMEM      = 1'b0;
                end
                ST_T2: begin
                    case (w_class)
                        CLS_ALU: begin
                            rf_o1sel   = rf_osel(w_rd);
                            rf_o2sel   = rf_osel(w_rs);
                            funsel_alu = ALU_OP[w_opcode];
                            MUXSelA    = MUXA_ALU;
                            regsel_rf  = rf_onehot(w_rd);
                            funsel_rf  = FS_LOAD;
                        end
                        CLS_MEM: begin
                            outbsel = OUT_AR;
                            csMEM   = 1'b0;
                        end
                        CLS_BR: begin
                            if (w_br_take) begin
                                MUXSelB    = MUXB_IR;
                                regsel_arf = ARF_PC;
                                funsel_arf = FS_LOAD;
                            end
                        end
                        CLS_LDI: begin
                            MUXSelA   = MUXA_IR;
                            regsel_rf = rf_onehot(w_rd);
                            funsel_rf = FS_LOAD;
                        end
                        CLS_MOV: begin
                            rf_o1sel   = rf_osel(w_rs);
                            funsel_alu = ALU_PASS_A;
                            MUXSelA    = MUXA_ALU;
                            regsel_rf  = rf_onehot(w_rd);
                            funsel_rf  = FS_LOAD;
                        end
                        CLS_LDAR: begin
                            MUXSelB    = MUXB_IR;
                            regsel_arf = ARF_AR;
                            funsel_arf = FS_LOAD;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_T3: begin
                    outbsel = OUT_AR;
                    csMEM   = 1'b0;
                    if (w_opcode == OP_LD) begin
                        MUXSelA   = MUXA_MEM;
                        regsel_rf = rf_onehot(w_rd);
                        funsel_rf = FS_LOAD;
                    end else begin
                        wrMEM    = 1'b1;
                        MUXSelC  = MUXC_RF;
                        rf_o1sel = rf_osel(w_rs);
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction output model checked every cycle, plus literal pins.
// Drives the IR word and ALU flags; no flow control.
module tb_control_unit;
    import control_unit_pkg::*;

    typedef struct packed {
        logic       ir_en;
        logic       ir_lh;
        logic [1:0] fs_ir;
        logic [3:0] rs_arf;
        logic [1:0] fs_arf;
        logic [1:0] oa;
        logic [1:0] ob;
        logic [3:0] rs_rf;
        logic [3:0] tsel;
        logic [1:0] fs_rf;
        logic [2:0] o1;
        logic [2:0] o2;
        logic [3:0] alu;
        logic [1:0] ma;
        logic [1:0] mb;
        logic       mc;
        logic       wr;
        logic       cs;
        logic       hl;
    } outs_t;

    localparam logic [1:0] FS_LD = 2'b10;
    localparam logic [1:0] FS_IN = 2'b01;
    localparam outs_t IDLE_V  = '{cs: 1'b1, default: '0};
    localparam outs_t RESET_V = '{rs_arf: 4'b0111, fs_arf: 2'b11, cs: 1'b1, default: '0};
    localparam outs_t HALT_V  = '{hl: 1'b1, cs: 1'b1, default: '0};

    logic        clock;
    logic        reset_n;
    logic [15:0] ir_in;
    logic [3:0]  alu_flag;
    logic        IR_enable, IR_lh, MUXSelC, wrMEM, csMEM, halted;
    logic [1:0]  funsel_IR, funsel_arf, outasel, outbsel, funsel_rf, MUXSelA, MUXSelB;
    logic [3:0]  regsel_arf, regsel_rf, rf_tsel, funsel_alu;
    logic [2:0]  rf_o1sel, rf_o2sel;

    outs_t act;
    outs_t exp;
    logic  exp_vld;
    logic  mz;
    string cur_name;
    int    n_vec;
    int    n_bad;

    control_unit dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ir_in      (ir_in),
        .alu_flag   (alu_flag),
        .IR_enable  (IR_enable),
        .IR_lh      (IR_lh),
        .funsel_IR  (funsel_IR),
        .regsel_arf (regsel_arf),
        .funsel_arf (funsel_arf),
        .outasel    (outasel),
        .outbsel    (outbsel),
        .regsel_rf  (regsel_rf),
        .rf_tsel    (rf_tsel),
        .funsel_rf  (funsel_rf),
        .rf_o1sel   (rf_o1sel),
        .rf_o2sel   (rf_o2sel),
        .funsel_alu (funsel_alu),
        .MUXSelA    (MUXSelA),
        .MUXSelB    (MUXSelB),
        .MUXSelC    (MUXSelC),
        .wrMEM      (wrMEM),
        .csMEM      (csMEM),
        .halted     (halted)
    );

    assign act = {IR_enable, IR_lh, funsel_IR, regsel_arf, funsel_arf, outasel, outbsel,
                  regsel_rf, rf_tsel, funsel_rf, rf_o1sel, rf_o2sel, funsel_alu,
                  MUXSelA, MUXSelB, MUXSelC, wrMEM, csMEM, halted};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    // Expected outputs for cycle k (0-based) of an instruction, given the current Z.
    function automatic outs_t model(input logic [15:0] ins, input int k, input logic z);
        outs_t      o;
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        o  = IDLE_V;
        op = ins[15:12];
        rd = ins[11:10];
        rs = ins[9:8];
        if (k < 2) begin
            o.ir_en  = 1'b1;
            o.ir_lh  = (k == 1);
            o.fs_ir  = FS_LD;
            o.rs_arf = 4'b0001;
            o.fs_arf = FS_IN;
            o.ob     = OUT_PC;
            o.cs     = 1'b0;
        end else if (op == 4'h1 || op == 4'h2) begin
            o.ob = OUT_AR;
            o.cs = 1'b0;
            if (k == 3 && op == 4'h1) begin
                o.ma    = MUXA_MEM;
                o.rs_rf = 4'b0001 << rd;
                o.fs_rf = FS_LD;
            end else if (k == 3) begin
                o.wr = 1'b1;
                o.mc = MUXC_RF;
                o.o1 = {1'b1, rs};
            end
        end else if (op >= 4'h4 && op <= 4'h9) begin
            o.o1    = {1'b1, rd};
            o.o2    = {1'b1, rs};
            o.alu   = ALU_OP[op];
            o.ma    = MUXA_ALU;
            o.rs_rf = 4'b0001 << rd;
            o.fs_rf = FS_LD;
        end else if (op == 4'h0) begin
            o.ma    = MUXA_IR;
            o.rs_rf = 4'b0001 << rd;
            o.fs_rf = FS_LD;
        end else if (op == 4'h3) begin
            o.o1    = {1'b1, rs};
            o.alu   = ALU_PASS_A;
            o.ma    = MUXA_ALU;
            o.rs_rf = 4'b0001 << rd;
            o.fs_rf = FS_LD;
        end else if (op == 4'hD) begin
            o.mb     = MUXB_IR;
            o.rs_arf = 4'b0010;
            o.fs_arf = FS_LD;
        end else if (op == 4'hA || (op == 4'hB && z) || (op == 4'hC && !z)) begin
            o.mb     = MUXB_IR;
            o.rs_arf = 4'b0001;
            o.fs_arf = FS_LD;
        end
        return o;
    endfunction

    always @(negedge clock) begin
        if (exp_vld) chk(cur_name, 64'(act), 64'(exp));
    end

    task automatic cycle(input logic [15:0] ins, input int k);
        exp = model(ins, k, mz);
        exp_vld = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic cycle_mid(input logic [15:0] ins, input int k);
        exp = model(ins, k, mz);
        exp_vld = 1'b1;
        @(negedge clock);
        #1;
    endtask

    task automatic run_instr(input logic [15:0] ins, input logic [3:0] flag, input string name);
        int len;
        len = (ins[15:12] == 4'h1 || ins[15:12] == 4'h2) ? 4 : 3;
        ir_in = ins;
        alu_flag = flag;
        cur_name = name;
        for (int k = 0; k < len; k++) cycle(ins, k);
        if (ins[15:12] >= 4'h4 && ins[15:12] <= 4'h9) mz = flag[3];
    endtask

    // Fetch, then stop mid-T2 so the caller can pin literal values.
    task automatic begin_t2(input logic [15:0] ins, input logic [3:0] flag, input string name);
        ir_in = ins;
        alu_flag = flag;
        cur_name = name;
        cycle(ins, 0);
        cycle(ins, 1);
        cycle_mid(ins, 2);
    endtask

    task automatic end_t2(input logic [15:0] ins, input logic [3:0] flag);
        @(posedge clock);
        #1;
        if (ins[15:12] >= 4'h4 && ins[15:12] <= 4'h9) mz = flag[3];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_bad = 0;
        exp_vld = 1'b0; exp = IDLE_V; mz = 1'b0; cur_name = "idle";
        reset_n = 1'b0; ir_in = 16'h0000; alu_flag = 4'h0;
        #2;
        chk("reset_vec", 64'(act), 64'(RESET_V));
        chk("reset_halted", 64'(halted), 64'd0);
        @(posedge clock); #1;
        chk("reset_hold_vec", 64'(act), 64'(RESET_V));
        reset_n = 1'b1;

        begin_t2(16'h0405, 4'h0, "ldi");
        chk("ldi_regsel_rf", 64'(regsel_rf), 64'h2);
        chk("ldi_muxa", 64'(MUXSelA), 64'h2);
        chk("ldi_ir_en", 64'(IR_enable), 64'd0);
        end_t2(16'h0405, 4'h0);

        begin_t2(16'h5600, 4'b1000, "sub");
        chk("sub_alu", 64'(funsel_alu), 64'h6);
        chk("sub_o1o2", 64'({rf_o1sel, rf_o2sel}), 64'({3'b101, 3'b110}));
        end_t2(16'h5600, 4'b1000);

        begin_t2(16'hB040, 4'h0, "beq_z1");
        chk("beq_pc_load", 64'({regsel_arf, funsel_arf}), 64'({4'b0001, 2'b10}));
        end_t2(16'hB040, 4'h0);

        begin_t2(16'hC040, 4'h0, "bne_z1");
        chk("bne_regsel", 64'({regsel_arf, regsel_rf, rf_tsel}), 64'd0);
        end_t2(16'hC040, 4'h0);

        run_instr(16'h4100, 4'b0000, "add");
        run_instr(16'hC080, 4'h0, "bne_z0");
        run_instr(16'hB080, 4'h0, "beq_z0");
        run_instr(16'h6E00, 4'b1000, "and");
        run_instr(16'h7100, 4'b0111, "or");
        run_instr(16'h8C00, 4'b0000, "not");
        run_instr(16'h9400, 4'b1000, "inc");
        run_instr(16'h3600, 4'b0000, "mov");
        run_instr(16'hB011, 4'h0, "beq_after_mov");
        run_instr(16'hD020, 4'h0, "ldar");
        run_instr(16'hA010, 4'h0, "bra");
        run_instr(16'hE000, 4'b0000, "nop");
        run_instr(16'hBFFF, 4'h0, "beq_after_nop");
        run_instr(16'h1200, 4'h0, "ld");

        begin_t2(16'h2100, 4'h0, "st");
        chk("st_t2_wr", 64'(wrMEM), 64'd0);
        chk("st_t2_cs", 64'(csMEM), 64'd0);
        end_t2(16'h2100, 4'h0);
        cycle_mid(16'h2100, 3);
        chk("st_t3_wr_cs", 64'({wrMEM, csMEM}), 64'({1'b1, 1'b0}));
        @(posedge clock); #1;
        run_instr(16'h0405, 4'h0, "after_st");

        ir_in = 16'h2300; alu_flag = 4'h0; cur_name = "st_abort";
        cycle(16'h2300, 0);
        cycle(16'h2300, 1);
        cycle(16'h2300, 2);
        cycle_mid(16'h2300, 3);
        chk("abort_pre_wr", 64'(wrMEM), 64'd1);
        reset_n = 1'b0;
        exp_vld = 1'b0;
        #1;
        chk("abort_wr", 64'(wrMEM), 64'd0);
        chk("abort_vec", 64'(act), 64'(RESET_V));
        @(posedge clock); #1;
        reset_n = 1'b1;
        mz = 1'b0;
        run_instr(16'hB040, 4'h0, "beq_after_reset");

        run_instr(16'hF000, 4'h0, "hlt");
        cur_name = "halted";
        for (int i = 0; i < 20; i++) begin
            exp = HALT_V;
            exp_vld = 1'b1;
            @(posedge clock); #1;
        end
        chk("halt_flag", 64'(halted), 64'd1);
        exp_vld = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("halt_reset_flag", 64'(halted), 64'd0);
        chk("halt_reset_vec", 64'(act), 64'(RESET_V));
        @(posedge clock); #1;
        reset_n = 1'b1;
        mz = 1'b0;
        #1;
        chk("restart_t0_fetch", 64'({IR_enable, IR_lh, csMEM}), 64'({1'b1, 1'b0, 1'b0}));
        #1;
        run_instr(16'h0405, 4'h0, "ldi_after_halt");

        exp_vld = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have no parameters; all encodings come from the shared package.
REQ-002 SHALL have ports `clock` (input, 1) and `reset_n` (input, 1); one clock, and reset is asynchronous and active-low.
REQ-003 SHALL have these inputs:
- `ir_in`, 16 bits: IR contents.
- `alu_flag`, 4 bits: {Z,C,N,O}, combinational from the ALU.
REQ-004 SHALL have these IR control outputs:
- `IR_enable`, 1 bit.
- `IR_lh`, 1 bit: 0 = low byte, 1 = high byte.
- `funsel_IR`, 2 bits.
REQ-005 SHALL have these ARF control outputs:
- `regsel_arf`, 4 bits, one-hot: bit0 PC, bit1 AR, bit2 SP, bit3 PCpast.
- `funsel_arf`, 2 bits.
- `outasel` and `outbsel`, 2 bits each.
REQ-006 SHALL have these RF control outputs:
- `regsel_rf` and `rf_tsel`, 4 bits each, one-hot.
- `funsel_rf`, 2 bits.
- `rf_o1sel` and `rf_o2sel`, 3 bits each.
REQ-007 SHALL have these ALU, mux and memory outputs:
- `funsel_alu`, 4 bits.
- `MUXSelA` and `MUXSelB`, 2 bits each.
- `MUXSelC`, 1 bit.
- `wrMEM`, 1 bit: 1 = write.
- `csMEM`, 1 bit, active-low.
- `halted`, 1 bit.
REQ-008 SHALL assume register funsel encodings 00 = decrement, 01 = increment, 10 = load, 11 = clear; an all-zero regsel means every register holds.

Function
REQ-009 SHALL decode the instruction fields as:
- `ir_in[15:12]`: opcode.
- `ir_in[11:10]`: Rd (R1..R4).
- `ir_in[9:8]`: Rs.
- `ir_in[7:0]`: immediate/address.
REQ-010 SHALL be a Moore FSM with states T0, T1, T2, T3 and HALT; a 2-bit timing counter plus a halt flag is acceptable.
REQ-011 SHALL, in T0, perform the low-byte fetch:
- Memory: `csMEM`=0, `wrMEM`=0, `outbsel`=PC.
- IR: `IR_enable`=1, `IR_lh`=0, `funsel_IR`=load.
- PC: `regsel_arf`=PC, `funsel_arf`=increment.
- Next state: T1.
REQ-012 SHALL, in T1, repeat T0 with `IR_lh`=1 and go to T2.
REQ-013 SHALL, in T2, drive `IR_enable`=0 and execute per opcode; single-cycle opcodes return to T0.
REQ-014 SHALL, for ALU opcodes 4-9 (ADD, SUB, AND, OR, NOT, INC):
- Drive `rf_o1sel`=Rd, `rf_o2sel`=Rs, and `funsel_alu`=ALU_OP[opcode] from the package table.
- Select the ALU output as the RF write source via `MUXSelA`, then load Rd.
- Take 1 execute cycle.
REQ-015 SHALL handle the remaining single-cycle opcodes as follows:
- 0 LDI: Rd <- imm via `MUXSelA`=IR.
- 3 MOV: Rd <- Rs via the ALU pass-through.
- D LDAR: AR <- imm via `MUXSelB`=IR.
- A BRA: PC <- imm.
REQ-016 SHALL execute memory opcodes 1 LD and 2 ST in two execute cycles, T2 then T3:
- T2: drive `outbsel`=AR with `csMEM`=0.
- T3 for LD: Rd <- memory via `MUXSelA`=MEM.
- T3 for ST: `wrMEM`=1 with data = Rs via `MUXSelC`.
- Return to T0 after T3.
REQ-017 SHALL keep an internal Z register, loaded from `alu_flag[3]` at the end of T2 of ALU opcodes only.
REQ-018 SHALL handle conditional branches as follows:
- B BEQ and C BNE load PC <- imm when Z=1 and Z=0 respectively.
- When not taken, all regsel are zero.
- Either way the instruction takes 3 cycles.
REQ-019 SHALL treat opcode E as a NOP: 3 cycles, all regsel zero.
REQ-020 SHALL, on opcode F HLT, enter HALT and stay there until reset, with `halted`=1, every regsel zero, `csMEM`=1 and `IR_enable`=0.
REQ-021 SHALL drive, in every state, the idle value of each output not named for that state: regsel 0, `IR_enable` 0, `csMEM` 1, `wrMEM` 0, all other selects 0.
REQ-022 SHALL set latency to 3 cycles per instruction, 4 for LD/ST.
REQ-023 SHALL let PC wrap naturally from 0xFF to 0x00; the control unit takes no action.

Reset
REQ-024 SHALL, while `reset_n`=0, immediately force state T0, Z=0, `halted`=0, all outputs at idle, and additionally clear PC, AR and SP (`regsel_arf`=0111, `funsel_arf`=clear).
REQ-025 SHALL, when reset asserts mid-instruction, abort the instruction with no memory write; after reset is released, the first rising edge performs T0.

Structure
REQ-026 SHALL place in a shared package the opcode constants, the ALU_OP table, the state encoding, the funsel codes, and the MUXSel and outsel source codes.
REQ-027 SHALL implement a single sub-module `instr_decoder`: combinational, mapping opcode to class {ALU, MEM, BR, LDI, MOV, LDAR, NOP, HLT}.
REQ-028 SHALL put all remaining logic (FSM and output decode) in `control_unit`.

Verification
REQ-029 SHALL cover: release reset with memory word 0x0 / 0x4 (`ir_in`=0x0405) -> T0..T2 over 3 clocks, T2 drives Rd=R2 load with `MUXSelA`=IR, then T0.
REQ-030 SHALL cover: `ir_in`=0x5600 (SUB R2,R3) with `alu_flag`=1000 -> T2 `funsel_alu`=ALU_OP[5], Z becomes 1; next BEQ 0xB040 -> PC load asserted in T2.
REQ-031 SHALL cover: BNE 0xC040 with Z=1 -> T2 all regsel 0; next fetch uses the incremented PC.
REQ-032 SHALL cover: ST 0x2100 -> `wrMEM`=1 only in T3, `csMEM`=0 in T2 and T3, total 4 cycles.
REQ-033 SHALL cover: HLT 0xF000 -> `halted`=1 and the outputs stay idle for 20 cycles; `reset_n` pulse -> `halted`=0, T0.
REQ-034 SHALL cover: `reset_n` asserted during T3 of ST -> `wrMEM` drops to 0 immediately, with no clock edge needed.
